// File: rtl/axil_wr_arb.sv
// AXI4-Lite write-request arbiter: NREQ requesters share one write engine.
// Optional round-robin via AXIL_WR_ARB_RR_EN; default is fixed priority.
module axil_wr_arb #(
   parameter int NREQ  = 4,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic [NREQ*32-1:0] req_addr,
   input  logic [NREQ*32-1:0] req_data,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   output logic [31:0]       m_wr_addr,
   output logic [31:0]       m_wr_data,
   output logic              m_wr_valid,
   input  logic              m_wr_ready,
   output logic [NREQ-1:0]   grant,
   output logic              busy,
   output logic [CNT_W-1:0]  wr_count
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      ISSUE = 3'b010,
      DONE  = 3'b100
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [NREQ-1:0]   req_ready_nx;
   logic [NREQ-1:0]   grant_nx;
   logic              m_wr_valid_nx;
   logic              busy_nx;
   logic [31:0]       addr_nx;
   logic [31:0]       data_nx;
   logic [CNT_W-1:0]  cnt_nx;
   logic [IW-1:0]     win;
   logic [NREQ-1:0]   win_oh;
   logic [31:0]       sel_addr;
   logic [31:0]       sel_data;
   logic              any_req;

   assign any_req = |req_valid;

`ifdef AXIL_WR_ARB_RR_EN
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] rr_ptr_nx;
   logic          found;

   // Round-robin pick: first requester after the last owner.
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
            found = 1'b1;
            win   = IW'((int'(rr_ptr) + k) % NREQ);
         end
      end
   end
`else
   // Fixed priority pick: lowest index wins.
   always_comb begin
      win = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) win = IW'(i);
      end
   end
`endif

   // One-hot winner and its address/data.
   always_comb begin
      win_oh   = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == IW'(i)) begin
            win_oh[i] = 1'b1;
            sel_addr  = req_addr[32*i +: 32];
            sel_data  = req_data[32*i +: 32];
         end
      end
   end

   // Next state and next registered outputs.
   always_comb begin
      state_nx      = state;
      req_ready_nx  = '0;
      grant_nx      = grant;
      m_wr_valid_nx = m_wr_valid;
      addr_nx       = m_wr_addr;
      data_nx       = m_wr_data;
      cnt_nx        = wr_count;
`ifdef AXIL_WR_ARB_RR_EN
      rr_ptr_nx     = rr_ptr;
`endif
      case (state)
         IDLE: begin
            grant_nx      = '0;
            m_wr_valid_nx = 1'b0;
            if (any_req) begin
               state_nx      = ISSUE;
               grant_nx      = win_oh;
               m_wr_valid_nx = 1'b1;
               addr_nx       = sel_addr;
               data_nx       = sel_data;
`ifdef AXIL_WR_ARB_RR_EN
               rr_ptr_nx     = win;
`endif
            end
         end
         ISSUE: begin
            m_wr_valid_nx = 1'b1;
            if (m_wr_ready) begin
               state_nx      = DONE;
               m_wr_valid_nx = 1'b0;
               cnt_nx        = wr_count + CNT_W'(1);
               req_ready_nx  = grant;
            end
         end
         DONE: begin
            state_nx      = IDLE;
            grant_nx      = '0;
            m_wr_valid_nx = 1'b0;
         end
         default: begin
            state_nx      = IDLE;
            grant_nx      = '0;
            m_wr_valid_nx = 1'b0;
         end
      endcase
      busy_nx = (state_nx != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state      <= IDLE;
         req_ready  <= '0;
         grant      <= '0;
         m_wr_valid <= 1'b0;
         m_wr_addr  <= '0;
         m_wr_data  <= '0;
         busy       <= 1'b0;
         wr_count   <= '0;
      end else begin
         state      <= state_nx;
         req_ready  <= req_ready_nx;
         grant      <= grant_nx;
         m_wr_valid <= m_wr_valid_nx;
         m_wr_addr  <= addr_nx;
         m_wr_data  <= data_nx;
         busy       <= busy_nx;
         wr_count   <= cnt_nx;
      end
   end

`ifdef AXIL_WR_ARB_RR_EN
   // Round-robin pointer holds the last owner.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) rr_ptr <= IW'(NREQ - 1);
      else         rr_ptr <= rr_ptr_nx;
   end
`endif

endmodule

// File: doc/axil_wr_arb.md
AXIL_WR_ARB -- requirements
Module: axil_wr_arb

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (2..8).
REQ-002 Parameter: CNT_W, 16, width of the completed-write counter.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 arst_n  input  1  asynchronous active-low reset.
REQ-005 req_addr  input  NREQ*32  write address; requester i occupies bits [32*i+31:32*i].
REQ-006 req_data  input  NREQ*32  write data, packed the same way as req_addr.
REQ-007 req_valid  input  NREQ  per-requester write request; held until that requester's req_ready.
REQ-008 req_ready  output  NREQ  per-requester one-cycle completion pulse.
REQ-009 m_wr_addr  output  32  address to the AXI4-Lite write engine.
REQ-010 m_wr_data  output  32  data to the AXI4-Lite write engine.
REQ-011 m_wr_valid  output  1  request to the write engine.
REQ-012 m_wr_ready  input  1  write engine completion; the write is done when m_wr_valid and m_wr_ready are both high.
REQ-013 grant  output  NREQ  one-hot index of the current owner; all zero when idle.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 wr_count  output  CNT_W  number of completed writes.

Function
REQ-016 States: IDLE, ISSUE, DONE (one-hot encoded); all outputs registered.
REQ-017 IDLE, any req_valid high -> select winner, latch its addr/data into m_wr_addr/m_wr_data, set grant, go to ISSUE next cycle; no req_valid -> stay in IDLE.
REQ-018 ISSUE: m_wr_valid=1; m_wr_addr, m_wr_data and grant are stable; m_wr_ready=0 -> stay in ISSUE with no timeout.
REQ-019 ISSUE with m_wr_ready=1 -> DONE; m_wr_valid drops on that edge; wr_count increments, wrapping from all-ones to 0.
REQ-020 DONE: req_ready[owner]=1 for exactly one cycle, all other req_ready bits 0; then IDLE with grant cleared.
REQ-021 Minimum request-to-request spacing is 3 cycles; back-to-back grants are never issued from DONE.
REQ-022 req_valid changes and requester addr/data changes during ISSUE/DONE are ignored, because the latched copy is used.
REQ-023 A requester that drops req_valid before its req_ready still completes its write, and its req_ready pulse is still emitted.
REQ-024 Several req_valid bits high in the same IDLE cycle: exactly one winner, selected per REQ-030/REQ-031.
REQ-025 A request arriving while busy waits without limit; there is no queueing beyond req_valid itself.
REQ-026 Illegal state encoding -> IDLE on the next clock.

Reset
REQ-027 arst_n low asynchronously forces: state IDLE, req_ready=0, m_wr_valid=0, m_wr_addr=0, m_wr_data=0, grant=0, busy=0, wr_count=0, RR pointer=NREQ-1.
REQ-028 Reset during ISSUE abandons the transfer; no req_ready pulse follows and wr_count does not increment.
REQ-029 Deassertion is used as-is; synchronising the release to clk is done outside this block; the first arbitration happens in the first IDLE cycle after release.

Configuration
REQ-030 Macro AXIL_WR_ARB_RR_EN defined: round-robin; search starts at (last owner + 1) mod NREQ; pointer updates on entry to ISSUE.
REQ-031 Macro AXIL_WR_ARB_RR_EN undefined: fixed priority, lowest index wins; no pointer register is implemented.

Verification
REQ-032 Single request: req_valid=4'b0100, addr 0x10, data 0xDEADBEEF, m_wr_ready high 2 cycles after grant -> grant=4'b0100, m_wr_addr=0x10, req_ready[2] pulses once, wr_count=1.
REQ-033 Contention with RR on: req_valid=4'b1111 held, m_wr_ready tied 1 -> grant order 0,1,2,3,0 with 3-cycle spacing.
REQ-034 Contention with RR off: req_valid=4'b1010 held -> requester 1 wins repeatedly and requester 3 starves.
REQ-035 Stall: m_wr_ready low for 20 cycles -> m_wr_valid, addr, data and grant held steady; no req_ready.
REQ-036 Reset in ISSUE: arst_n pulsed low -> all outputs 0 immediately; after release, the pending request re-arbitrates; wr_count=0.
REQ-037 Counter wrap: CNT_W=4, 17 completed writes -> wr_count=1.
